// File: rtl/shell_axil_pkg.sv
// rtl/shell_axil_pkg.sv - shared constants and state encoding for the shell AXI4-Lite decoupler
package shell_axil_pkg;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [1:0]  RESP_SLVERR      = 2'b10;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEC0_DEAD;

  typedef enum logic [1:0] {
    PASS      = 2'd0,
    DRAIN     = 2'd1,
    DECOUPLED = 2'd2
  } dec_state_e;

endpackage

// File: rtl/shell_axil_outstanding_ctr.sv
// rtl/shell_axil_outstanding_ctr.sv - saturating up/down count of accepted-but-unanswered transactions
module shell_axil_outstanding_ctr #(
  parameter int MAX_COUNT = 4,
  parameter int CNT_WIDTH = $clog2(MAX_COUNT) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero
);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  assign full = (cnt == CNT_WIDTH'(MAX_COUNT));
  assign zero = (cnt == '0);

endmodule

// File: rtl/shell_axil_decoupler.sv
// rtl/shell_axil_decoupler.sv - AXI4-Lite isolation boundary between shell and a reconfigurable user partition
module shell_axil_decoupler
  import shell_axil_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 32,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          TIMEOUT_CYCLES  = 1024,
  parameter logic [31:0] ERR_DATA        = ERR_DATA_DEFAULT
) (
  input  logic                    shell_axi_clk,
  input  logic                    shell_rstn,
  input  logic                    decouple_req,
  output logic                    decouple_ack,
  output logic                    timeout_flag,

  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]              s_axil_awprot,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]              s_axil_arprot,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,

  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
);

  dec_state_e  state, state_next;
  logic [15:0] timer;
  logic        aw_sent, w_sent, req_q, loc_bvalid, loc_rvalid;
  logic        wr_full, wr_zero, rd_full, rd_zero;
  logic        in_pass, in_drain, in_dec;
  logic        wr_go, both_valid, aw_hs, w_hs, wr_done, loc_wr_acc, loc_rd_acc;
  logic        wr_inc, wr_dec, rd_inc, rd_dec;
  logic        drained, drain_tmo, forced;

  assign in_pass  = (state == PASS);
  assign in_drain = (state == DRAIN);
  assign in_dec   = (state == DECOUPLED);

  assign m_axil_awaddr = s_axil_awaddr;
  assign m_axil_awprot = s_axil_awprot;
  assign m_axil_wdata  = s_axil_wdata;
  assign m_axil_wstrb  = s_axil_wstrb;
  assign m_axil_araddr = s_axil_araddr;
  assign m_axil_arprot = s_axil_arprot;

  // A half-sent write keeps going through DRAIN so the user side never sees an orphan channel.
  assign wr_go          = (in_pass && !wr_full) || ((aw_sent || w_sent) && !in_dec);
  assign both_valid     = s_axil_awvalid && s_axil_wvalid;
  assign m_axil_awvalid = wr_go && both_valid && !aw_sent;
  assign m_axil_wvalid  = wr_go && both_valid && !w_sent;
  assign aw_hs          = m_axil_awvalid && m_axil_awready;
  assign w_hs           = m_axil_wvalid && m_axil_wready;
  assign wr_done        = (aw_sent || aw_hs) && (w_sent || w_hs);
  assign loc_wr_acc     = in_dec && decouple_req && wr_zero && !loc_bvalid && both_valid;
  assign s_axil_awready = wr_done || loc_wr_acc;
  assign s_axil_wready  = wr_done || loc_wr_acc;

  assign m_axil_arvalid = in_pass && !rd_full && s_axil_arvalid;
  assign loc_rd_acc     = in_dec && decouple_req && rd_zero && !loc_rvalid && s_axil_arvalid;
  assign s_axil_arready = (m_axil_arvalid && m_axil_arready) || loc_rd_acc;

  // Once decoupled, leftover counted responses are synthesised before any local one.
  always_comb begin
    s_axil_bvalid = m_axil_bvalid;
    s_axil_bresp  = m_axil_bresp;
    m_axil_bready = s_axil_bready;
    s_axil_rvalid = m_axil_rvalid;
    s_axil_rresp  = m_axil_rresp;
    s_axil_rdata  = m_axil_rdata;
    m_axil_rready = s_axil_rready;
    if (in_dec) begin
      s_axil_bvalid = !wr_zero || loc_bvalid;
      s_axil_bresp  = RESP_SLVERR;
      m_axil_bready = 1'b1;
      s_axil_rvalid = !rd_zero || loc_rvalid;
      s_axil_rresp  = RESP_SLVERR;
      s_axil_rdata  = DATA_WIDTH'(ERR_DATA);
      m_axil_rready = 1'b1;
    end
  end

  assign wr_inc = wr_done;
  assign wr_dec = s_axil_bvalid && s_axil_bready && (!in_dec || !wr_zero);
  assign rd_inc = m_axil_arvalid && m_axil_arready;
  assign rd_dec = s_axil_rvalid && s_axil_rready && (!in_dec || !rd_zero);

  shell_axil_outstanding_ctr #(.MAX_COUNT(MAX_OUTSTANDING)) u_wr_ctr (
    .clk   (shell_axi_clk),
    .rst_n (shell_rstn),
    .inc   (wr_inc),
    .dec   (wr_dec),
    .full  (wr_full),
    .zero  (wr_zero)
  );

  shell_axil_outstanding_ctr #(.MAX_COUNT(MAX_OUTSTANDING)) u_rd_ctr (
    .clk   (shell_axi_clk),
    .rst_n (shell_rstn),
    .inc   (rd_inc),
    .dec   (rd_dec),
    .full  (rd_full),
    .zero  (rd_zero)
  );

  assign drained   = wr_zero && rd_zero && !aw_sent && !w_sent;
  assign drain_tmo = in_drain && (timer == 16'(TIMEOUT_CYCLES - 1));
  assign forced    = drain_tmo && !drained;

  always_comb begin
    state_next = state;
    case (state)
      PASS:      if (decouple_req) state_next = DRAIN;
      DRAIN:     if (drained || drain_tmo) state_next = DECOUPLED;
      DECOUPLED: if (!decouple_req && wr_zero && rd_zero && !loc_bvalid && !loc_rvalid)
                   state_next = PASS;
      default:   state_next = PASS;
    endcase
  end

  always_ff @(posedge shell_axi_clk or negedge shell_rstn) begin
    if (!shell_rstn) begin
      state        <= PASS;
      timer        <= '0;
      req_q        <= 1'b0;
      decouple_ack <= 1'b0;
      timeout_flag <= 1'b0;
      aw_sent      <= 1'b0;
      w_sent       <= 1'b0;
      loc_bvalid   <= 1'b0;
      loc_rvalid   <= 1'b0;
    end else begin
      state        <= state_next;
      req_q        <= decouple_req;
      decouple_ack <= in_dec;
      timer        <= in_drain ? timer + 16'd1 : 16'd0;
      if (forced)
        timeout_flag <= 1'b1;
      else if (decouple_req && !req_q)
        timeout_flag <= 1'b0;
      aw_sent <= (aw_sent || aw_hs) && !wr_done && !forced;
      w_sent  <= (w_sent || w_hs) && !wr_done && !forced;
      if (loc_wr_acc)
        loc_bvalid <= 1'b1;
      else if (loc_bvalid && wr_zero && s_axil_bready)
        loc_bvalid <= 1'b0;
      if (loc_rd_acc)
        loc_rvalid <= 1'b1;
      else if (loc_rvalid && rd_zero && s_axil_rready)
        loc_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shell_axil_decoupler.sv
// tb/tb_shell_axil_decoupler.sv - randomized self-checking bench for shell_axil_decoupler
module tb_shell_axil_decoupler;
  import shell_axil_pkg::*;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          MAXO = 4;
  localparam int          TMO  = 16;
  localparam logic [31:0] ERRD = 32'hDEC0_DEAD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic decouple_req, decouple_ack, timeout_flag;
  logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [2:0] s_awprot, s_arprot, m_awprot, m_arprot;
  logic [DW-1:0] s_wdata, s_rdata, m_wdata, m_rdata;
  logic [DW/8-1:0] s_wstrb, m_wstrb;
  logic [1:0] s_bresp, s_rresp, m_bresp, m_rresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;

  shell_axil_decoupler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERRD)
  ) dut (
    .shell_axi_clk(clk), .shell_rstn(rst_n),
    .decouple_req(decouple_req), .decouple_ack(decouple_ack), .timeout_flag(timeout_flag),
    .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot), .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready),
    .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready),
    .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
    .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
    .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Shell-visible memory (reference) and the user partition's memory built from what reaches it.
  logic [31:0] ref_mem  [8];
  logic [31:0] user_mem [8];
  logic [31:0] user_rq [$];
  logic [31:0] exp_rq  [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] all_outs();
    return {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, m_awvalid,
            m_wvalid, m_arvalid, m_bready, m_rready, decouple_ack, timeout_flag};
  endfunction

  task automatic pass_write(input logic [2:0] idx, input logic [31:0] data);
    bit aw_done = 0;
    bit w_done  = 0;
    int guard   = 0;
    logic [31:0] ua = '0;
    logic [31:0] ud = '0;
    s_awaddr = {27'd0, idx, 2'b00};
    s_wdata = data; s_wstrb = '1; s_awvalid = 1; s_wvalid = 1;
    while (!(aw_done && w_done) && guard < 40) begin
      m_awready = 1'($urandom_range(0, 1));
      m_wready  = 1'($urandom_range(0, 1));
      #1;
      check("aw_join_valid", m_awvalid, !aw_done);
      check("w_join_valid", m_wvalid, !w_done);
      if (m_awvalid && m_awready) begin aw_done = 1; ua = m_awaddr; end
      if (m_wvalid && m_wready) begin w_done = 1; ud = m_wdata; end
      check("aw_w_ready_pair", {s_awready, s_wready}, {2{aw_done && w_done}});
      tick;
      guard++;
    end
    check("write_completed", aw_done && w_done, 1);
    s_awvalid = 0; s_wvalid = 0; m_awready = 0; m_wready = 0;
    ref_mem[idx] = data;
    user_mem[ua[4:2]] = ud;
  endtask

  task automatic user_b(input logic [1:0] resp, input int delay);
    repeat (delay) tick;
    m_bvalid = 1; m_bresp = resp; s_bready = 1;
    #1;
    check("b_pass_valid", s_bvalid, 1);
    check("b_pass_resp", s_bresp, resp);
    check("b_pass_ready", m_bready, 1);
    tick;
    m_bvalid = 0; s_bready = 0;
  endtask

  task automatic pass_ar(input logic [2:0] idx);
    s_araddr = {27'd0, idx, 2'b00}; s_arvalid = 1; m_arready = 1;
    #1;
    check("ar_zero_latency", {s_arready, m_arvalid}, 2'b11);
    if (s_arready) begin
      user_rq.push_back(m_araddr);
      exp_rq.push_back(ref_mem[idx]);
      check("ar_addr_pass", m_araddr, s_araddr);
    end
    tick;
    s_arvalid = 0; m_arready = 0;
  endtask

  task automatic user_r(input int delay);
    logic [31:0] ua, ed;
    repeat (delay) tick;
    check("r_queue_depth", 64'(user_rq.size()), 64'(exp_rq.size()));
    if (user_rq.size() == 0 || exp_rq.size() == 0) return;
    ua = user_rq.pop_front();
    ed = exp_rq.pop_front();
    m_rdata = user_mem[ua[4:2]]; m_rresp = RESP_OKAY; m_rvalid = 1; s_rready = 1;
    #1;
    check("r_pass_valid", s_rvalid, 1);
    check("r_pass_data", s_rdata, ed);
    check("r_pass_resp", s_rresp, RESP_OKAY);
    check("r_pass_ready", m_rready, 1);
    tick;
    m_rvalid = 0; s_rready = 0;
  endtask

  task automatic wait_ack(input logic lvl, input string tag, input int exp_cycles);
    int n = 0;
    do begin
      tick;
      n++;
    end while (decouple_ack !== lvl && n < 50);
    check(tag, n, exp_cycles);
  endtask

  initial begin
    int n;
    logic [1:0] br;
    logic [31:0] d;
    decouple_req = 0;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
    m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
    m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;
    for (int i = 0; i < 8; i++) begin ref_mem[i] = '0; user_mem[i] = '0; end

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 12'd0);
    rst_n = 1;
    tick;

    pass_write(3'd4, 32'hA5A5_A5A5);
    user_b(RESP_OKAY, 0);
    pass_ar(3'd4);
    user_r(0);

    for (int it = 0; it < 10; it++) begin
      d  = $urandom;
      br = ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY;
      pass_write(3'($urandom_range(0, 7)), d);
      user_b(br, $urandom_range(0, 3));
      pass_ar(3'($urandom_range(0, 7)));
      user_r($urandom_range(0, 3));
    end

    for (int i = 0; i < MAXO; i++) pass_ar(3'($urandom_range(0, 7)));
    s_araddr = {27'd0, 3'd4, 2'b00}; s_arvalid = 1; m_arready = 1;
    #1;
    check("ar_stall_at_max", {s_arready, m_arvalid}, 2'b00);
    user_r(0);
    s_arvalid = 1; m_arready = 1;
    #1;
    check("ar_after_r_accept", s_arready, 1);
    if (s_arready) begin user_rq.push_back(m_araddr); exp_rq.push_back(ref_mem[4]); end
    tick;
    s_arvalid = 0; m_arready = 0;
    for (int i = 0; i < MAXO; i++) user_r($urandom_range(0, 2));

    pass_write(3'd1, $urandom);
    pass_write(3'd2, $urandom);
    decouple_req = 1;
    tick;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; m_awready = 1; m_wready = 1; m_arready = 1;
    #1;
    check("drain_stall", {s_awready, s_wready, s_arready, m_awvalid, m_wvalid, m_arvalid}, 6'd0);
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; m_awready = 0; m_wready = 0; m_arready = 0;
    repeat (4) tick;
    check("drain_no_ack", decouple_ack, 0);
    user_b(RESP_OKAY, 0);
    user_b(RESP_OKAY, 0);
    wait_ack(1'b1, "drain_ack_latency", 2);
    check("drain_no_timeout", timeout_flag, 0);
    decouple_req = 0;
    wait_ack(1'b0, "release_ack_latency", 2);

    pass_ar(3'($urandom_range(0, 7)));
    decouple_req = 1;
    n = 0;
    do begin tick; n++; end while (!s_rvalid && n < 100);
    check("tmo_latency", n, TMO + 1);
    check("tmo_rresp", s_rresp, RESP_SLVERR);
    check("tmo_rdata", s_rdata, ERRD);
    check("tmo_flag_set", timeout_flag, 1);
    tick;
    check("tmo_ack", decouple_ack, 1);
    s_rready = 1;
    tick;
    s_rready = 0;
    check("tmo_resp_once", s_rvalid, 0);
    void'(user_rq.pop_front());
    void'(exp_rq.pop_front());
    m_rvalid = 1; m_rdata = $urandom;
    #1;
    check("late_r_absorbed", {m_rready, s_rvalid}, 2'b10);
    tick;
    m_rvalid = 0;

    s_awaddr = 32'h20; s_wdata = $urandom; s_awvalid = 1; s_wvalid = 1; s_bready = 0;
    m_awready = 1; m_wready = 1;
    #1;
    check("dec_wr_accept", {s_awready, s_wready}, 2'b11);
    check("dec_no_m_write", {m_awvalid, m_wvalid}, 2'b00);
    check("dec_b_not_yet", s_bvalid, 0);
    tick;
    check("dec_b_valid", s_bvalid, 1);
    check("dec_b_slverr", s_bresp, RESP_SLVERR);
    check("dec_second_held", {s_awready, s_wready}, 2'b00);
    s_awvalid = 0; s_wvalid = 0; m_awready = 0; m_wready = 0;
    m_bvalid = 1; m_bresp = RESP_OKAY; s_bready = 1;
    #1;
    check("late_b_ready", m_bready, 1);
    tick;
    check("late_b_absorbed", s_bvalid, 0);
    m_bvalid = 0; s_bready = 0;

    s_araddr = 32'h24; s_arvalid = 1; m_arready = 1;
    #1;
    check("dec_rd_accept", {s_arready, m_arvalid}, 2'b10);
    tick;
    s_arvalid = 0; m_arready = 0;
    check("dec_r_local", {s_rvalid, s_rresp, s_rdata}, {1'b1, RESP_SLVERR, ERRD});
    s_rready = 1;
    tick;
    s_rready = 0;
    check("dec_r_taken", s_rvalid, 0);

    decouple_req = 0;
    wait_ack(1'b0, "exit_ack_latency", 2);
    check("tmo_flag_sticky", timeout_flag, 1);
    decouple_req = 1;
    tick;
    check("tmo_flag_clear", timeout_flag, 0);
    wait_ack(1'b1, "reenter_ack_latency", 2);
    decouple_req = 0;
    wait_ack(1'b0, "reexit_ack_latency", 2);

    pass_ar(3'($urandom_range(0, 7)));
    decouple_req = 1;
    tick;
    tick;
    decouple_req = 0;
    tick;
    s_arvalid = 1; m_arready = 1;
    #1;
    check("drain_ignores_req_drop", {s_arready, m_arvalid}, 2'b00);
    s_arvalid = 0; m_arready = 0;
    #2;
    rst_n = 0;
    #1;
    check("async_reset_outputs", all_outs(), 12'd0);
    user_rq.delete();
    exp_rq.delete();
    repeat (2) tick;
    rst_n = 1;
    tick;
    s_arvalid = 1; m_arready = 1;
    #1;
    check("pass_after_reset", {s_arready, m_arvalid, s_rvalid}, 3'b110);
    tick;
    s_arvalid = 0; m_arready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/shell_axil_decoupler.md
Name: shell_axil_decoupler

Overview:
- Parametrised AXI4-Lite boundary between the shell control path (slave side, s_) and the user partition (master side, m_).
- Allows the user partition to be isolated for reconfiguration. On request it stops new traffic and drains outstanding transactions, with a timeout.
- While decoupled, the shell side is answered locally with SLVERR, so the host never hangs on an unresponsive user region.

Parameters:
- ADDR_WIDTH, 32, address width of both sides.
- DATA_WIDTH, 32, data width (32 or 64); strobe width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions per direction (read, write); power of 2.
- TIMEOUT_CYCLES, 1024, drain cycles allowed before forced decouple; range 2..65535.
- ERR_DATA, 32'hDEC0_DEAD, rdata returned on locally generated read errors; zero-extended to DATA_WIDTH.

Ports:
- shell_axi_clk  in  1  sole clock.
- shell_rstn  in  1  asynchronous active-low reset.
- decouple_req  in  1  level; 1 = isolate user partition.
- decouple_ack  out  1  1 = isolation complete (DECOUPLED state).
- timeout_flag  out  1  sticky; set when a drain timed out.
- s_axil_aw{addr,prot,valid} / awready  in / out  ADDR_WIDTH,3,1 / 1  shell write address.
- s_axil_w{data,strb,valid} / wready  in / out  DATA_WIDTH,DATA_WIDTH/8,1 / 1  shell write data.
- s_axil_b{resp,valid} / bready  out / in  2,1 / 1  shell write response.
- s_axil_ar{addr,prot,valid} / arready  in / out  ADDR_WIDTH,3,1 / 1  shell read address.
- s_axil_r{data,resp,valid} / rready  out / in  DATA_WIDTH,2,1 / 1  shell read data.
- m_axil_*  mirror of s_axil_* with directions reversed  user-partition side.

Behaviour:
- Reset: asynchronous, active-low on shell_rstn. All outputs are low after reset: valids, readies, decouple_ack, timeout_flag, counters. State is PASS.
- State machine (PASS, DRAIN, DECOUPLED):
  - PASS -> DRAIN when decouple_req=1.
  - DRAIN -> DECOUPLED when wr_cnt=0 and rd_cnt=0, or when the drain timer reaches TIMEOUT_CYCLES-1.
  - DECOUPLED -> PASS when decouple_req=0 and no local response is pending.
  - DRAIN -> PASS is not allowed, even if the request drops.
- PASS data path:
  - AW, W and AR pass through combinationally (zero latency), gated by state.
  - Write join: m_awvalid and m_wvalid are asserted only when both s_awvalid and s_wvalid are high. Per-channel "sent" flags handle an AW and W accepted on different cycles.
  - s_awready and s_wready pulse together in the cycle the second of the two handshakes completes.
  - B and R pass through combinationally in PASS and DRAIN.
- Counters:
  - wr_cnt increments on the completed AW+W pair and decrements on the s_b handshake. rd_cnt works the same with AR and R.
  - Simultaneous increment and decrement leaves the count unchanged.
  - At MAX_OUTSTANDING, new requests of that direction are stalled (s ready low, m valid low).
- DRAIN:
  - All s_ request readies are low; m_ request valids are low.
  - A write with only one of AW/W sent completes its remaining channel before the stall takes effect.
  - The timer starts at 0 on entry and increments each cycle.
  - On timeout: timeout_flag is set, and the remaining wr_cnt/rd_cnt responses are synthesised locally, one per cycle on handshake, with resp=SLVERR(2'b10) and rdata=ERR_DATA.
- DECOUPLED:
  - m_bready=m_rready=1, so late user responses are discarded; m request valids are 0.
  - Each s_ request is accepted with a 1-cycle registered turnaround: the response is valid the cycle after the handshake, with SLVERR (and ERR_DATA for reads).
  - Only one local response per direction is outstanding; readies are held low until it is taken.
  - decouple_ack=1 is registered and asserted the cycle after entry.
- timeout_flag is cleared on the cycle decouple_req rises from 0.
- Reset mid-transaction drops everything; no response is generated.

Decomposition:
- Package shell_axil_pkg:
  - resp constants (RESP_OKAY, RESP_SLVERR);
  - state enum (PASS, DRAIN, DECOUPLED);
  - the default ERR_DATA constant.
- One sub-module, shell_axil_outstanding_ctr, instantiated twice (read and write). It provides the saturating up/down counter with a full flag and a zero flag.

Test Plan:
- PASS write then read at 0x10, data 0xA5A5A5A5, user replies OKAY -> shell sees OKAY and rdata 0xA5A5A5A5; zero added latency on all channels.
- Issue 4 reads with user R stalled -> 5th AR is stalled (s_arready=0); after one R, the 5th is accepted.
- 2 writes outstanding, raise decouple_req, user answers both after 20 cycles -> DECOUPLED at cycle ~21, decouple_ack=1, timeout_flag=0.
- 1 read outstanding, user never answers, TIMEOUT_CYCLES=16 -> after 16 cycles, shell gets rresp=2'b10 with rdata=ERR_DATA; timeout_flag=1; ack=1.
- In DECOUPLED, write 0x20 -> bresp=SLVERR one cycle after handshake; m_awvalid stays 0; a late user B is absorbed.
- Deassert decouple_req -> PASS, ack=0; reassert -> timeout_flag clears.
- Assert shell_rstn=0 mid-drain -> all outputs are 0 immediately, asynchronously.
